// File: rtl/axis_sa_pkg.sv
// Shared types and constants for the axis_sa systolic array and its output reorder buffer.
package axis_sa_pkg;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} bank_state_e;

    localparam int SA_WX = 4;
    localparam int SA_WK = 4;
    localparam int SA_K  = 2;
    localparam int SA_WY = SA_WX + SA_WK + $clog2(SA_K);

    // Index width that never collapses to zero for single-entry dimensions.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sa_tile_bank.sv
// One R x C result tile: column write port, row read port, and a per-column written mask.
module sa_tile_bank
    import axis_sa_pkg::*;
#(
    parameter int R  = 2,
    parameter int C  = 2,
    parameter int WY = 10,
    localparam int CW = idx_w(C),
    localparam int RW = idx_w(R)
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            clr,
    input  logic            wr_en,
    input  logic [CW-1:0]   wr_col,
    input  logic [R*WY-1:0] wr_data,
    input  logic [RW-1:0]   rd_row,
    output logic [C*WY-1:0] rd_data
);

    logic [C-1:0][R-1:0][WY-1:0] mem_q, mem_d;
    logic [C-1:0]                mask_q, mask_d;

    always_comb begin
        mem_d  = mem_q;
        mask_d = mask_q;
        if (clr) mask_d = '0;
        if (wr_en) begin
            mem_d[wr_col]  = wr_data;
            mask_d[wr_col] = 1'b1;
        end
    end

    // Tile data needs no reset: the mask hides anything not written this tile.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) mask_q <= '0;
        else       mask_q <= mask_d;
    end

    always_comb begin
        rd_data = '0;
        for (int c = 0; c < C; c++) begin
            if (mask_q[c]) rd_data[c*WY +: WY] = mem_q[c][rd_row];
        end
    end

endmodule

// File: rtl/axis_sa_col2row.sv
// Ping-pong reorder buffer: accepts axis_sa column beats (last column first), emits row-major beats.
module axis_sa_col2row
    import axis_sa_pkg::*;
#(
    parameter int R  = 2,
    parameter int C  = 2,
    parameter int WY = 10
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [R*WY-1:0] s_data,
    input  logic            s_last,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [C*WY-1:0] m_data,
    output logic            m_last,
    output logic            err
);

    localparam int CW = idx_w(C);
    localparam int RW = idx_w(R);

    bank_state_e   state_q [2];
    bank_state_e   state_d [2];
    logic          wb_q, wb_d, rb_q, rb_d, err_q, err_d;
    logic [CW-1:0] ic_q, ic_d;
    logic [RW-1:0] orow_q, orow_d;
    logic          s_hs, m_hs, col_end, row_end, close, drain;
    logic [1:0][C*WY-1:0] rd_data;

    assign s_ready = (state_q[wb_q] == EMPTY);
    assign m_valid = (state_q[rb_q] == FULL);
    assign col_end = (ic_q == CW'(C - 1));
    assign row_end = (orow_q == RW'(R - 1));
    assign s_hs    = s_valid && s_ready;
    assign m_hs    = m_valid && m_ready;
    // A tile closes on s_last or on its C-th beat, whichever comes first.
    assign close   = s_hs && (s_last || col_end);
    assign drain   = m_hs && row_end;
    assign m_last  = m_valid && row_end;
    assign m_data  = rd_data[rb_q];
    assign err     = err_q;

    always_comb begin
        state_d = state_q;
        wb_d    = wb_q;
        rb_d    = rb_q;
        ic_d    = ic_q;
        orow_d  = orow_q;
        err_d   = s_hs && (s_last != col_end);
        if (close) begin
            state_d[wb_q] = FULL;
            wb_d          = ~wb_q;
            ic_d          = '0;
        end else if (s_hs) begin
            ic_d = ic_q + 1'b1;
        end
        // Filling and draining banks always differ, so both updates apply together.
        if (drain) begin
            state_d[rb_q] = EMPTY;
            rb_d          = ~rb_q;
            orow_d        = '0;
        end else if (m_hs) begin
            orow_d = orow_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= '{default: EMPTY};
            wb_q    <= 1'b0;
            rb_q    <= 1'b0;
            ic_q    <= '0;
            orow_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wb_q    <= wb_d;
            rb_q    <= rb_d;
            ic_q    <= ic_d;
            orow_q  <= orow_d;
            err_q   <= err_d;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        sa_tile_bank #(.R(R), .C(C), .WY(WY)) u_bank (
            .clk     (clk),
            .rstn    (rstn),
            .clr     (drain && (rb_q == 1'(b))),
            .wr_en   (s_hs && (wb_q == 1'(b))),
            .wr_col  (CW'(C - 1) - ic_q),
            .wr_data (s_data),
            .rd_row  (orow_q),
            .rd_data (rd_data[b])
        );
    end

endmodule

// File: tb/tb_axis_sa_col2row.sv
// Scoreboard bench for axis_sa_col2row: tile-level reference model, monitor-side checking.
module tb_axis_sa_col2row;

    localparam int R  = 2;
    localparam int C  = 2;
    localparam int WY = 10;

    typedef struct {
        logic [C*WY-1:0] d;
        logic            l;
        int              cyc;
    } row_t;

    logic            clk = 1'b0, rstn = 1'b1;
    logic            s_valid = 1'b0, s_last = 1'b0, m_ready = 1'b0;
    logic [R*WY-1:0] s_data = '0;
    logic            s_ready, m_valid, m_last, err;
    logic [C*WY-1:0] m_data;

    int vectors = 0, miscompares = 0;
    int p_valid = 100, p_ready = 100;
    int cyc = 0, errs = 0, sready_lo = 0;

    row_t exp_q[$], pend_rows[$], log_q[$];
    logic [WY-1:0] mcol [C][R];
    bit   mwr [C];
    int   mic = 0;
    bit   err_pend = 0, mclose = 0;
    row_t mrow;

    always #5 clk = ~clk;

    axis_sa_col2row #(.R(R), .C(C), .WY(WY)) dut (
        .clk(clk), .rstn(rstn),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .err(err)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [2*WY-1:0] w2(input int a, input int b);
        return {WY'(b), WY'(a)};
    endfunction

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        m_ready = ($urandom_range(99) < p_ready);
    end

    // Reference model: collects columns of a tile, emits its rows once the tile closes.
    always @(negedge clk) begin
        if (!rstn) begin
            mic = 0;
            err_pend = 0;
            foreach (mwr[c]) mwr[c] = 0;
            pend_rows.delete();
        end else begin
            chk("err", err, err_pend);
            err_pend = 0;
            if (s_valid && s_ready) begin
                for (int r = 0; r < R; r++) mcol[C-1-mic][r] = s_data[r*WY +: WY];
                mwr[C-1-mic] = 1;
                err_pend = (s_last != (mic == C - 1));
                mclose   = s_last || (mic == C - 1);
                if (mclose) begin
                    for (int r = 0; r < R; r++) begin
                        mrow.d = '0;
                        for (int c = 0; c < C; c++)
                            if (mwr[c]) mrow.d[c*WY +: WY] = mcol[c][r];
                        mrow.l   = (r == R - 1);
                        mrow.cyc = 0;
                        pend_rows.push_back(mrow);
                    end
                    foreach (mwr[c]) mwr[c] = 0;
                    mic = 0;
                end else begin
                    mic++;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rstn) while (pend_rows.size() != 0) exp_q.push_back(pend_rows.pop_front());
    end

    // Monitor: every cycle the output side must match the scoreboard head.
    always @(negedge clk) begin
        if (rstn) begin
            if (err) errs++;
            if (!s_ready) sready_lo++;
            chk("m_valid", m_valid, exp_q.size() != 0);
            chk("s_ready", s_ready, ((exp_q.size() + R - 1) / R) < 2);
            if (m_valid && exp_q.size() != 0) begin
                chk("m_data", m_data, exp_q[0].d);
                chk("m_last", m_last, exp_q[0].l);
                if (m_ready) begin
                    log_q.push_back('{m_data, m_last, cyc});
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic send_beat(input logic [R*WY-1:0] d, input logic l);
        int n = 0;
        while ($urandom_range(99) >= p_valid) begin
            @(posedge clk); #1;
        end
        s_valid = 1'b1; s_data = d; s_last = l;
        forever begin
            @(negedge clk);
            if (s_ready) break;
            n++;
            if (n > 300) begin
                vectors++; miscompares++;
                $display("FAIL s_handshake_timeout: got no handshake expected one within 300 cycles");
                break;
            end
        end
        @(posedge clk); #1;
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 || pend_rows.size() != 0) begin
            @(posedge clk); #1;
            n++;
            if (n > 500) begin
                vectors++; miscompares++;
                $display("FAIL drain_timeout: got %0d rows left expected 0", exp_q.size());
                exp_q.delete();
                break;
            end
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rstn = 1'b0; s_valid = 1'b0; s_last = 1'b0;
        exp_q.delete();
        #1;
        chk("rst_s_ready", s_ready, 1'b1);
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_m_last", m_last, 1'b0);
        chk("rst_err", err, 1'b0);
        repeat (2) @(posedge clk);
        #2 rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic chk_log(input string nm, input int i, input logic [C*WY-1:0] d, input logic l);
        if (i >= log_q.size()) chk({nm, "_count"}, log_q.size(), i + 1);
        else begin
            chk({nm, "_data"}, log_q[i].d, d);
            chk({nm, "_last"}, log_q[i].l, l);
        end
    endtask

    initial begin
        int e0, k, s0;
        logic [C*WY-1:0] bp_exp [6];
        bit lst;

        do_reset();

        // Basic tile, including one-cycle close-to-valid latency.
        p_ready = 100; p_valid = 100; log_q.delete(); e0 = errs;
        send_beat(w2(6, 12), 1'b0);
        send_beat(w2(-15, 25), 1'b1);
        @(negedge clk);
        chk("latency_m_valid", m_valid, 1'b1);
        wait_drain();
        chk_log("basic0", 0, w2(-15, 6), 1'b0);
        chk_log("basic1", 1, w2(25, 12), 1'b1);
        chk("basic_err", errs - e0, 0);

        // Back-to-back tiles stream without bubbles.
        log_q.delete(); s0 = sready_lo;
        repeat (2) begin
            send_beat(w2(6, 12), 1'b0);
            send_beat(w2(-15, 25), 1'b1);
        end
        wait_drain();
        chk("b2b_rows", log_q.size(), 4);
        for (int i = 1; i < 4 && i < log_q.size(); i++)
            chk("b2b_gap", log_q[i].cyc - log_q[i-1].cyc, 1);
        chk("b2b_s_ready_low", sready_lo - s0, 0);

        // Backpressure: two tiles fill both banks, the third stalls.
        p_ready = 0; repeat (2) @(posedge clk); #1;
        log_q.delete();
        send_beat(w2(1, 2), 1'b0); send_beat(w2(3, 4), 1'b1);
        send_beat(w2(5, 6), 1'b0); send_beat(w2(7, 8), 1'b1);
        @(negedge clk);
        chk("bp_s_ready_full", s_ready, 1'b0);
        fork
            begin
                send_beat(w2(9, 10), 1'b0);
                send_beat(w2(11, 12), 1'b1);
            end
            begin
                repeat (10) @(negedge clk);
                chk("bp_stall_s_ready", s_ready, 1'b0);
                chk("bp_stall_rows", log_q.size(), 0);
                p_ready = 100;
            end
        join
        wait_drain();
        bp_exp = '{w2(3, 1), w2(4, 2), w2(7, 5), w2(8, 6), w2(11, 9), w2(12, 10)};
        for (int i = 0; i < 6; i++) chk_log("bp", i, bp_exp[i], (i % 2) == 1);

        // Early s_last: missing columns read as zero.
        log_q.delete(); e0 = errs;
        send_beat(w2(6, 12), 1'b1);
        wait_drain();
        chk_log("early0", 0, w2(0, 6), 1'b0);
        chk_log("early1", 1, w2(0, 12), 1'b1);
        chk("early_err", errs - e0, 1);

        // Missing s_last: tile closes on its own, third beat opens the next tile.
        log_q.delete(); e0 = errs;
        send_beat(w2(1, 2), 1'b0); send_beat(w2(3, 4), 1'b0);
        send_beat(w2(5, 6), 1'b0); send_beat(w2(7, 8), 1'b1);
        wait_drain();
        chk_log("miss0", 0, w2(3, 1), 1'b0);
        chk_log("miss1", 1, w2(4, 2), 1'b1);
        chk_log("miss2", 2, w2(7, 5), 1'b0);
        chk_log("miss3", 3, w2(8, 6), 1'b1);
        chk("miss_err", errs - e0, 1);

        // Reset mid-tile, then a clean tile.
        p_ready = 50;
        send_beat(w2(3, 3), 1'b0);
        do_reset();
        log_q.delete();
        send_beat(w2(6, 12), 1'b0);
        send_beat(w2(-15, 25), 1'b1);
        wait_drain();
        chk_log("post_rst0", 0, w2(-15, 6), 1'b0);
        chk_log("post_rst1", 1, w2(25, 12), 1'b1);

        // Random traffic with occasional framing faults.
        p_valid = 70; p_ready = 60; k = 0;
        for (int i = 0; i < 300; i++) begin
            lst = (k == C - 1);
            if ($urandom_range(9) == 0) lst = ~lst;
            send_beat(R*WY'($urandom), lst);
            k = (lst || k == C - 1) ? 0 : k + 1;
        end
        p_ready = 100;
        wait_drain();
        chk("final_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
